lcd_spi_byte_writer: RTL

//  Serialises one 9-bit LCD word {dc, byte[7:0]} onto the st7735 4-wire SPI bus: mode 0, MSB first, one byte per CS frame.

---
 rtl/lcd_spi_byte_writer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/lcd_spi_byte_writer.sv
// Serialises one 9-bit LCD word {dc, byte} onto the st7735 4-wire SPI bus (mode 0, MSB first),
// one byte per chip-select frame, followed by a guard gap so the upstream provider can advance its data.
`timescale 1ns/1ps
module lcd_spi_byte_writer #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       en_write,
    input  logic [8:0] data,
    output logic       wr_done,
    output logic       busy,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_dc,
    output logic       lcd_cs_n
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, GAP} state_t;

    localparam logic [3:0] HALF_LAST = 4'(CLK_DIV - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t     r_state, w_stateNext;
    logic [3:0] r_halfCnt, w_halfCntNext;
    logic [2:0] r_bitCnt, w_bitCntNext;
    logic [7:0] r_shreg, w_shregNext;
    logic       r_wrDone, w_wrDoneNext;
    logic       r_busy, w_busyNext;
    logic       r_sclk, w_sclkNext;
    logic       r_mosi, w_mosiNext;
    logic       r_dc, w_dcNext;
    logic       r_csN, w_csNNext;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= IDLE;
            r_halfCnt <= '0;
            r_bitCnt  <= '0;
            r_shreg   <= '0;
            r_wrDone  <= 1'b0;
            r_busy    <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_dc      <= 1'b0;
            r_csN     <= 1'b1;
        end else begin
            r_state   <= w_stateNext;
            r_halfCnt <= w_halfCntNext;
            r_bitCnt  <= w_bitCntNext;
            r_shreg   <= w_shregNext;
            r_wrDone  <= w_wrDoneNext;
            r_busy    <= w_busyNext;
            r_sclk    <= w_sclkNext;
            r_mosi    <= w_mosiNext;
            r_dc      <= w_dcNext;
            r_csN     <= w_csNNext;
        end
    end

    // r_sclk doubles as the phase flag inside SHIFT: high phase ends by shifting, low phase ends the bit
    always_comb begin
        w_stateNext   = r_state;
        w_halfCntNext = r_halfCnt;
        w_bitCntNext  = r_bitCnt;
        w_shregNext   = r_shreg;
        w_wrDoneNext  = 1'b0;
        w_sclkNext    = r_sclk;
        w_mosiNext    = r_mosi;
        w_dcNext      = r_dc;
        w_csNNext     = r_csN;
        case (r_state)
            IDLE: begin
                w_halfCntNext = '0;
                w_bitCntNext  = '0;
                if (en_write) begin
                    w_shregNext = data[7:0];
                    w_dcNext    = data[8];
                    w_mosiNext  = data[7];
                    w_csNNext   = 1'b0;
                    w_stateNext = LOAD;
                end
            end
            LOAD: begin
                if (r_halfCnt == HALF_LAST) begin
                    w_halfCntNext = '0;
                    w_bitCntNext  = 3'd7;
                    w_sclkNext    = 1'b1;
                    w_stateNext   = SHIFT;
                end else begin
                    w_halfCntNext = r_halfCnt + 4'd1;
                end
            end
            SHIFT: begin
                if (r_halfCnt != HALF_LAST) begin
                    w_halfCntNext = r_halfCnt + 4'd1;
                end else begin
                    w_halfCntNext = '0;
                    if (r_sclk) begin
                        w_sclkNext  = 1'b0;
                        w_shregNext = {r_shreg[6:0], 1'b0};
                        w_mosiNext  = r_shreg[6];
                    end else if (r_bitCnt == 3'd0) begin
                        w_csNNext    = 1'b1;
                        w_mosiNext   = 1'b0;
                        w_wrDoneNext = 1'b1;
                        w_stateNext  = DONE;
                    end else begin
                        w_bitCntNext = r_bitCnt - 3'd1;
                        w_sclkNext   = 1'b1;
                    end
                end
            end
            DONE: begin
                w_halfCntNext = '0;
                w_stateNext   = GAP;
            end
            GAP: begin
                if (r_halfCnt == GAP_LAST) begin
                    w_halfCntNext = '0;
                    w_stateNext   = IDLE;
                end else begin
                    w_halfCntNext = r_halfCnt + 4'd1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_sclkNext  = 1'b0;
                w_csNNext   = 1'b1;
            end
        endcase
        w_busyNext = (w_stateNext != IDLE);
    end

    assign wr_done  = r_wrDone;
    assign busy     = r_busy;
    assign lcd_sclk = r_sclk;
    assign lcd_mosi = r_mosi;
    assign lcd_dc   = r_dc;
    assign lcd_cs_n = r_csN;
endmodule
